// File: rtl/multicyclecontrol.sv
// Multicycle sequencing controller: walks each instruction through fetch, decode,
// execute, memory and writeback, with a bounded ready handshake on the shared memory port.
module multicyclecontrol #(
  parameter int unsigned MEMWAIT_MAX = 15,
  parameter int unsigned CNTW        = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [31:0]     instruction,
  input  logic            memready,
  input  logic            memread_d,
  input  logic            memwrite_d,
  input  logic            regwrite_d,
  input  logic [1:0]      jump_d,
  output logic            memreq,
  output logic            memwe,
  output logic            imemsel,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            regwrite,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [2:0]      state,
  output logic [CNTW-1:0] cyclecount,
  output logic [CNTW-1:0] instrcount
);

  localparam int unsigned WW = (MEMWAIT_MAX < 1) ? 1 : $clog2(MEMWAIT_MAX + 1);
  localparam logic [WW-1:0]   WAIT_LIMIT = WW'(MEMWAIT_MAX);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [WW-1:0]   r_wait;
  logic [WW-1:0]   w_wait_next;
  logic [CNTW-1:0] r_cyclecount;
  logic [CNTW-1:0] r_instrcount;
  logic            w_busy;

  // State, wait counter and saturating activity counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_cyclecount <= '0;
      r_instrcount <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_wait_next;
      if (w_busy && (r_cyclecount != CNT_MAX)) r_cyclecount <= r_cyclecount + CNTW'(1);
      if (pcwrite && (r_instrcount != CNT_MAX)) r_instrcount <= r_instrcount + CNTW'(1);
    end
  end

  // Next state plus the memready-qualified strobes; the wait counter only survives
  // while a FETCH or MEMORY access is stalled, so every entry starts it from zero.
  always_comb begin
    w_next_state = r_state;
    w_wait_next  = '0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (memready) begin
          irwrite      = 1'b1;
          w_next_state = (instruction == 32'h0) ? S_HALT : S_DECODE;
        end else if (r_wait == WAIT_LIMIT) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_DECODE: w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (memwrite_d || memread_d) begin
          w_next_state = S_MEMORY;
        end else if (regwrite_d || (jump_d == 2'b11)) begin
          w_next_state = S_WRITEBACK;
        end else begin
          pcwrite      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_MEMORY: begin
        if (memready) begin
          if (memwrite_d) begin
            pcwrite      = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (r_wait == WAIT_LIMIT) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_WRITEBACK: begin
        pcwrite      = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    w_busy     = (r_state >= S_FETCH) && (r_state <= S_WRITEBACK);
    busy       = w_busy;
    memreq     = (r_state == S_FETCH) || (r_state == S_MEMORY);
    imemsel    = (r_state == S_FETCH);
    memwe      = (r_state == S_MEMORY) && memwrite_d;
    regwrite   = (r_state == S_WRITEBACK);
    halted     = (r_state == S_HALT);
    error      = (r_state == S_ERROR);
    state      = r_state;
    cyclecount = r_cyclecount;
    instrcount = r_instrcount;
  end

endmodule
